// File: rtl/firmware_boot_loader.sv
// -----------------------------------------------------------------------------
// firmware_boot_loader
//
// Boot-time copy engine between the firmware ROM and system RAM. On start it
// reads FW_SIZE bytes from the ROM (waiting ROM_LATENCY cycles per byte),
// writes each byte to RAM at DEST_BASE + index through a write/ready
// handshake, accumulates an 8-bit checksum of the accepted bytes and holds
// the CPU in reset until the whole image has been written.
//
// Ports
//   clk             in   clock, rising-edge active
//   rst             in   asynchronous active-high reset
//   start           in   begins a copy when idle or done (ignored while busy)
//   fw_address      out  ROM byte address (current index)
//   fw_data         in   ROM read data
//   SELECT_firmware out  ROM select, high only while reading
//   ram_address     out  RAM write address
//   ram_data        out  RAM write data
//   ram_write       out  RAM write request
//   ram_ready       in   RAM accepts the write when high with ram_write
//   cpu_reset       out  high until the image is fully loaded
//   busy            out  copy in progress
//   done            out  copy finished
//   checksum        out  mod-256 sum of accepted bytes
// -----------------------------------------------------------------------------
module firmware_boot_loader #(
    parameter int          FW_SIZE     = 16384,
    parameter logic [15:0] DEST_BASE   = 16'h0000,
    parameter int          ROM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [13:0] fw_address,
    input  logic [7:0]  fw_data,
    output logic        SELECT_firmware,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_write,
    input  logic        ram_ready,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic [7:0]  checksum
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0]  LAT_LAST = 3'(ROM_LATENCY - 1);
    localparam logic [14:0] IDX_LAST = 15'(FW_SIZE - 1);

    logic [1:0]  r_state;
    logic [14:0] r_index;
    logic [2:0]  r_lat;
    logic [7:0]  r_dreg;

    logic [13:0] r_fw_address;
    logic        r_select;
    logic [15:0] r_ram_address;
    logic [7:0]  r_ram_data;
    logic        r_ram_write;
    logic        r_cpu_reset;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_checksum;

    logic [14:0] w_index_next;
    logic [15:0] w_ram_address;

    assign w_index_next  = r_index + 15'd1;
    // Destination wraps naturally in 16 bits.
    assign w_ram_address = DEST_BASE + {1'b0, r_index};

    // Every output is a register; the state machine loads the values the
    // next state needs on the same edge it changes state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the reset is asynchronous so an abort mid-copy drops
            // ram_write immediately, before any further edge can accept it.
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_lat         <= '0;
            r_dreg        <= '0;
            r_fw_address  <= '0;
            r_select      <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_write   <= 1'b0;
            r_cpu_reset   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_checksum    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_READ;
                        r_index      <= '0;
                        r_lat        <= '0;
                        r_checksum   <= '0;
                        r_cpu_reset  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_select     <= 1'b1;
                        r_fw_address <= '0;
                    end
                end

                ST_READ: begin
                    if (r_lat == LAT_LAST) begin
                        // ROM data has settled: capture it and present the write.
                        r_dreg        <= fw_data;
                        r_lat         <= '0;
                        r_state       <= ST_WRITE;
                        r_select      <= 1'b0;
                        r_ram_write   <= 1'b1;
                        r_ram_address <= w_ram_address;
                        r_ram_data    <= fw_data;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end

                ST_WRITE: begin
                    if (ram_ready) begin
                        r_checksum    <= r_checksum + r_dreg;
                        r_ram_write   <= 1'b0;
                        r_ram_address <= '0;
                        r_ram_data    <= '0;
                        if (r_index == IDX_LAST) begin
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_index      <= w_index_next;
                            r_state      <= ST_READ;
                            r_select     <= 1'b1;
                            r_fw_address <= w_index_next[13:0];
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fw_address      = r_fw_address;
    assign SELECT_firmware = r_select;
    assign ram_address     = r_ram_address;
    assign ram_data        = r_ram_data;
    assign ram_write       = r_ram_write;
    assign cpu_reset       = r_cpu_reset;
    assign busy            = r_busy;
    assign done            = r_done;
    assign checksum        = r_checksum;

endmodule

// File: tb/tb_firmware_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_firmware_boot_loader
//
// Three copies of the boot loader with different parameter sets share one
// clock and reset:
//   0: FW_SIZE=4,     ROM_LATENCY=1, DEST_BASE=8000  (basic, start, abort)
//   1: FW_SIZE=4,     ROM_LATENCY=3, DEST_BASE=FFFE  (stall, wrap, random ready)
//   2: FW_SIZE=16384, ROM_LATENCY=1, DEST_BASE=0000  (full-size image)
// A ROM model returns corrupted data until the address has been stable for
// the configured latency. Accepted writes are collected and compared with
// the list implied by the ROM contents, along with checksum and timing.
// -----------------------------------------------------------------------------
module tb_firmware_boot_loader;

    localparam int          CFG_SIZE [3] = '{4, 4, 16384};
    localparam int          CFG_LAT  [3] = '{1, 3, 1};
    localparam logic [15:0] CFG_BASE [3] = '{16'h8000, 16'hFFFE, 16'h0000};
    localparam logic [50:0] RESET_VEC =
        {14'd0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       start = '0;
    logic [2:0]       ram_ready = '1;
    logic [2:0][7:0]  fw_data;
    logic [2:0][13:0] fw_address;
    logic [2:0]       sel;
    logic [2:0][15:0] ram_address;
    logic [2:0][7:0]  ram_data;
    logic [2:0]       ram_write;
    logic [2:0]       cpu_reset;
    logic [2:0]       busy;
    logic [2:0]       done;
    logic [2:0][7:0]  checksum;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        firmware_boot_loader #(
            .FW_SIZE    (CFG_SIZE[g]),
            .DEST_BASE  (CFG_BASE[g]),
            .ROM_LATENCY(CFG_LAT[g])
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start[g]),
            .fw_address     (fw_address[g]),
            .fw_data        (fw_data[g]),
            .SELECT_firmware(sel[g]),
            .ram_address    (ram_address[g]),
            .ram_data       (ram_data[g]),
            .ram_write      (ram_write[g]),
            .ram_ready      (ram_ready[g]),
            .cpu_reset      (cpu_reset[g]),
            .busy           (busy[g]),
            .done           (done[g]),
            .checksum       (checksum[g])
        );
    end

    // ---------------- ROM model ----------------
    logic [7:0]  rom [16384];
    int          stable_cnt [3] = '{0, 0, 0};
    logic [14:0] last_key   [3] = '{default: '0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if ({sel[k], fw_address[k]} != last_key[k]) begin
                stable_cnt[k] <= 0;
                last_key[k]   <= {sel[k], fw_address[k]};
            end else begin
                stable_cnt[k] <= stable_cnt[k] + 1;
            end
        end
    end

    // Data is only correct once select/address have been stable long enough.
    always_comb begin
        fw_data = '0;
        for (int k = 0; k < 3; k++) begin
            if (sel[k] && stable_cnt[k] >= CFG_LAT[k] - 1)
                fw_data[k] = rom[fw_address[k]];
            else
                fw_data[k] = rom[fw_address[k]] ^ 8'hA5;
        end
    end

    // ---------------- write collector ----------------
    int          cur = 0;
    logic [23:0] wq [$];

    always @(posedge clk) begin
        if (!rst && ram_write[cur] && ram_ready[cur])
            wq.push_back({ram_address[cur], ram_data[cur]});
    end

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    function automatic logic [50:0] out_vec(input int k);
        return {fw_address[k], sel[k], ram_address[k], ram_data[k], ram_write[k],
                cpu_reset[k], busy[k], done[k], checksum[k]};
    endfunction

    function automatic logic [23:0] exp_write(input int k, input int i);
        return {16'(CFG_BASE[k] + 16'(i)), rom[i]};
    endfunction

    function automatic logic [7:0] exp_sum(input int k);
        int s = 0;
        for (int i = 0; i < CFG_SIZE[k]; i++) s += int'(rom[i]);
        return 8'(s);
    endfunction

    // Index of the first collected write that disagrees with the image, -1 if none.
    function automatic int first_bad_write(input int k);
        for (int i = 0; i < CFG_SIZE[k]; i++) begin
            if (i >= wq.size()) return i;
            if (wq[i] !== exp_write(k, i)) return i;
        end
        if (wq.size() != CFG_SIZE[k]) return CFG_SIZE[k];
        return -1;
    endfunction

    function automatic logic [23:0] got_write(input int i);
        if (i < wq.size()) return wq[i];
        return 24'hxxxxxx;
    endfunction

    // ---------------- stimulus driver ----------------
    // Starts a copy on instance k and runs until done or the budget expires.
    // cycles counts edges after the start edge; stalls counts edges where a
    // pending write was refused.
    task automatic run_copy(input int k, input bit hold_start, input int pulse_at,
                            input int stall_n, input bit rand_ready,
                            output int cycles, output int stalls);
        int          stall_left = stall_n;
        bit          snap_valid = 1'b0;
        logic [50:0] snap = '0;
        cur = k;
        wq.delete();
        @(negedge clk);
        start[k]     = 1'b1;
        ram_ready[k] = 1'b1;
        @(posedge clk);
        cycles = 0;
        stalls = 0;
        while (cycles < 40000) begin
            @(negedge clk);
            if (!hold_start) start[k] = (pulse_at != 0 && cycles == pulse_at);
            if (snap_valid) begin
                n_cmp++;
                if (out_vec(k) !== snap) begin
                    n_err++;
                    $display("FAIL stall_hold[%0d]: got %h want %h", k, out_vec(k), snap);
                end
                if (stall_left == 0) snap_valid = 1'b0;
            end
            if (ram_write[k] && stall_left > 0 && ram_address[k] == 16'(CFG_BASE[k] + 16'd1)) begin
                if (!snap_valid) begin
                    snap       = out_vec(k);
                    snap_valid = 1'b1;
                end
                ram_ready[k] = 1'b0;
                stall_left--;
            end else begin
                ram_ready[k] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (ram_write[k] && !ram_ready[k]) stalls++;
            @(posedge clk);
            #1;
            cycles++;
            if (done[k]) break;
        end
        @(negedge clk);
        ram_ready[k] = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = '0;
        ram_ready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (out_vec(k) !== RESET_VEC) begin
                    n_err++;
                    $display("FAIL reset_state[%0d] cycle %0d: got %h want %h", k, c, out_vec(k), RESET_VEC);
                end
            end
        end
    endtask

    task automatic test_basic();
        int cyc, stl, bad;
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'hF0;
        run_copy(0, 1'b0, 0, 0, 1'b0, cyc, stl);
        n_cmp++;
        if (cyc !== 8) begin n_err++; $display("FAIL basic_latency: got %0d want 8", cyc); end
        n_cmp++;
        if ({done[0], cpu_reset[0], busy[0]} !== 3'b100) begin
            n_err++; $display("FAIL basic_flags: got %b want 100", {done[0], cpu_reset[0], busy[0]});
        end
        n_cmp++;
        if (checksum[0] !== 8'h56) begin n_err++; $display("FAIL basic_checksum: got %h want 56", checksum[0]); end
        bad = first_bad_write(0);
        n_cmp++;
        if (bad != -1) begin
            n_err++;
            $display("FAIL basic_writes: entry %0d got %h want %h (count %0d)", bad, got_write(bad), exp_write(0, bad), wq.size());
        end
        n_cmp++;
        if (got_write(3) !== 24'h8003F0) begin n_err++; $display("FAIL basic_last_write: got %h want 8003f0", got_write(3)); end
    endtask

    task automatic test_backpressure();
        int cyc0, cyc1, stl, bad;
        run_copy(1, 1'b0, 0, 0, 1'b0, cyc0, stl);
        n_cmp++;
        if (cyc0 !== 16) begin n_err++; $display("FAIL nostall_latency: got %0d want 16", cyc0); end
        bad = first_bad_write(1);
        n_cmp++;
        if (bad != -1) begin
            n_err++;
            $display("FAIL wrap_writes: entry %0d got %h want %h", bad, got_write(bad), exp_write(1, bad));
        end
        n_cmp++;
        if (got_write(2) !== {16'h0000, rom[2]}) begin
            n_err++; $display("FAIL wrap_addr: got %h want %h", got_write(2), {16'h0000, rom[2]});
        end
        run_copy(1, 1'b0, 0, 2, 1'b0, cyc1, stl);
        n_cmp++;
        if (cyc1 !== cyc0 + 2) begin n_err++; $display("FAIL stall_latency: got %0d want %0d", cyc1, cyc0 + 2); end
        bad = first_bad_write(1);
        n_cmp++;
        if (bad != -1) begin
            n_err++;
            $display("FAIL stall_writes: entry %0d got %h want %h (count %0d)", bad, got_write(bad), exp_write(1, bad), wq.size());
        end
        n_cmp++;
        if (checksum[1] !== exp_sum(1)) begin n_err++; $display("FAIL stall_checksum: got %h want %h", checksum[1], exp_sum(1)); end
    endtask

    task automatic test_random_ready();
        int cyc, stl, bad;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) rom[i] = 8'($urandom);
            run_copy(1, 1'b0, 0, 0, 1'b1, cyc, stl);
            n_cmp++;
            if (cyc !== 16 + stl) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", r, cyc, 16 + stl); end
            bad = first_bad_write(1);
            n_cmp++;
            if (bad != -1) begin
                n_err++;
                $display("FAIL rand_writes[%0d]: entry %0d got %h want %h", r, bad, got_write(bad), exp_write(1, bad));
            end
            n_cmp++;
            if (checksum[1] !== exp_sum(1)) begin n_err++; $display("FAIL rand_checksum[%0d]: got %h want %h", r, checksum[1], exp_sum(1)); end
        end
    endtask

    task automatic test_start_handling();
        int cyc, stl, bad, n;
        // start pulsed mid-copy must be ignored
        run_copy(0, 1'b0, 3, 0, 1'b0, cyc, stl);
        n_cmp++;
        if (cyc !== 8) begin n_err++; $display("FAIL pulse_latency: got %0d want 8", cyc); end
        bad = first_bad_write(0);
        n_cmp++;
        if (bad != -1) begin
            n_err++; $display("FAIL pulse_writes: entry %0d got %h want %h (count %0d)", bad, got_write(bad), exp_write(0, bad), wq.size());
        end
        // start held high: one copy, then an immediate restart from DONE
        run_copy(0, 1'b1, 0, 0, 1'b0, cyc, stl);
        n_cmp++;
        if (cyc !== 8 || wq.size() !== 4) begin
            n_err++; $display("FAIL hold_first: got %0d cycles %0d writes want 8 cycles 4 writes", cyc, wq.size());
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy[0], done[0], cpu_reset[0], sel[0], fw_address[0], checksum[0]} !== {4'b1011, 14'd0, 8'd0}) begin
            n_err++;
            $display("FAIL restart_state: got %h want %h",
                     {busy[0], done[0], cpu_reset[0], sel[0], fw_address[0], checksum[0]}, {4'b1011, 14'd0, 8'd0});
        end
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done[0]) break;
        end
        n_cmp++;
        if (n !== 8) begin n_err++; $display("FAIL restart_latency: got %0d want 8", n); end
        n_cmp++;
        if (checksum[0] !== exp_sum(0)) begin n_err++; $display("FAIL restart_checksum: got %h want %h", checksum[0], exp_sum(0)); end
        n_cmp++;
        if (wq.size() !== 8) begin n_err++; $display("FAIL restart_count: got %0d want 8", wq.size()); end
    endtask

    task automatic test_mid_reset();
        int cyc, stl, bad, n;
        bit seen;
        cur = 0;
        wq.delete();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        seen = 1'b0;
        for (n = 0; n < 20 && !seen; n++) begin
            if (ram_write[0]) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL abort_reach_write: got no write want write within 20 cycles"); end
        ram_ready[0] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_vec(0) !== RESET_VEC) begin n_err++; $display("FAIL abort_outputs: got %h want %h", out_vec(0), RESET_VEC); end
        ram_ready[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (wq.size() !== 0) begin n_err++; $display("FAIL abort_no_write: got %0d writes want 0", wq.size()); end
        run_copy(0, 1'b0, 0, 0, 1'b0, cyc, stl);
        bad = first_bad_write(0);
        n_cmp++;
        if (bad != -1 || cyc !== 8) begin
            n_err++;
            $display("FAIL abort_recopy: entry %0d got %h want %h, cycles %0d want 8", bad, got_write(bad), exp_write(0, bad), cyc);
        end
    endtask

    task automatic test_full_size();
        int cyc, stl, bad;
        for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
        run_copy(2, 1'b0, 0, 0, 1'b0, cyc, stl);
        n_cmp++;
        if (cyc !== 32768) begin n_err++; $display("FAIL full_latency: got %0d want 32768", cyc); end
        n_cmp++;
        if (fw_address[2] !== 14'h3FFF) begin n_err++; $display("FAIL full_last_addr: got %h want 3fff", fw_address[2]); end
        n_cmp++;
        if (checksum[2] !== exp_sum(2)) begin n_err++; $display("FAIL full_checksum: got %h want %h", checksum[2], exp_sum(2)); end
        bad = first_bad_write(2);
        n_cmp++;
        if (bad != -1) begin
            n_err++;
            $display("FAIL full_writes: entry %0d got %h want %h (count %0d)", bad, got_write(bad), exp_write(2, bad), wq.size());
        end
        n_cmp++;
        if ({done[2], cpu_reset[2]} !== 2'b10) begin n_err++; $display("FAIL full_flags: got %b want 10", {done[2], cpu_reset[2]}); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_backpressure();
        test_random_ready();
        test_start_handling();
        test_mid_reset();
        test_full_size();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
